demux_32_bit_4dest: RTL and testbench
=====================================

# demux_32_bit_4dest

Routes a single 32-bit producer stream to one of four one-entry holding slots, selected by a 2-bit destination code. It is the write-side counterpart of the datapath's 4-way 32-bit select muxes: a result, for example from the ALU or memory, is steered into a per-destination buffer. Each buffer is then drained independently by its consumer through a valid/ack handshake.

## Interface
- DATA_W, 32, data width of input and every slot
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_W  word to be steered
- in_valid  input  1  producer offers in_data this cycle
- in_dest  input  2  destination slot index (0..3)
- in_ready  output  1  the slot selected by in_dest can accept a word this cycle
- out_0, out_1, out_2, out_3  output  DATA_W each  registered slot contents
- out_valid  output  4  bit i set when slot i holds an unconsumed word
- out_ack  input  4  bit i: consumer i takes out_i this cycle (ignored when out_valid[i]=0)
- occupancy  output  3  number of set bits in out_valid (0..4)
- drop_err  output  1  sticky; set when in_valid=1 and in_ready=0

## Operation
- Each slot is a one-entry buffer with flag v[i] and data register d[i].
- Write accept: in_valid && in_ready. Slot in_dest loads in_data, and v[in_dest] sets at the next edge.
- Drain: out_ack[i] && v[i] clears v[i] at the next edge. d[i] keeps its last value and is not zeroed.
- in_ready is combinational from in_dest, v, and (with the macro) out_ack. It is not a function of in_valid.
- Without the macro: in_ready = !v[in_dest].
- Write and ack on different slots in the same cycle: both take effect.
- Write and ack on the same slot in the same cycle, macro off: in_ready=0, so the write is refused and the ack clears v.
- Stalled offer: the producer must hold in_data and in_dest stable while in_valid=1 and in_ready=0.
- drop_err: the block drops nothing. It sets drop_err when the producer deasserts in_valid before acceptance, i.e. in_valid falls while the previous cycle had in_valid=1 and in_ready=0. drop_err clears only on rst.
- occupancy is registered and always equals popcount(out_valid). It is updated in the same edge as v.
- Unused out_ack bits (slot empty) produce no effect.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk):
  - v=4'b0000, d[i]=0, occupancy=0, drop_err=0
  - in_ready=1 for any in_dest (macro-independent)
- Latency: one cycle. A word accepted at edge N is visible on out_i with out_valid[i]=1 after edge N.
- Throughput per slot, macro off: one word every 2 cycles (accept, then ack, then accept).
- Across slots: one word per cycle when consecutive words target empty slots.
- Reset mid-operation: all buffered words are discarded immediately, with no partial write.

## Configuration
- DEMUX_ACK_BYPASS_EN defined:
  - in_ready = !v[in_dest] || out_ack[in_dest].
  - Same-slot write plus ack in one cycle replaces the word: d loads the new word and v stays 1.
  - occupancy is unchanged for that slot.
  - Per-slot throughput becomes 1 word/cycle.
- DEMUX_ACK_BYPASS_EN undefined: same-slot write plus ack behaves as in Operation. This adds no combinational path from out_ack to in_ready.

## Structure
- Package demux_pkg holds:
  - DEST_COUNT=4 and DEST_W=2
  - typedef dest_t (logic [1:0])
  - named slot constants DEST_0..DEST_3
- Sub-module demux_slot is one per destination, instantiated four times.
  - Ports: clk, rst, wr_en, wr_data, ack, data, valid.
  - It holds v/d and implements the load/clear/replace rule under the macro.
- Top level contains the in_dest decode, in_ready mux, occupancy register and drop_err logic.

## Test plan
- Reset check: assert rst mid-run with v=4'b1011 -> out_valid=0, occupancy=0, drop_err=0, in_ready=1, all outputs 0 in the same cycle.
- Four back-to-back writes:
  - Stimulus: in_dest 0,1,2,3 with data 32'h11111111..32'h44444444, in_valid=1, no acks.
  - Response: accepted on 4 consecutive edges, out_valid=4'b1111, occupancy=4.
- Full-slot stall:
  - Stimulus: slot 2 valid, offer 32'hDEADBEEF to in_dest=2 with no ack.
  - Response: in_ready=0, out_2 unchanged. Ack slot 2, then the write is accepted the following cycle and out_2=32'hDEADBEEF.
- Same-slot write plus ack:
  - Macro off: the write is refused, v[1] clears, then the write lands one cycle later.
  - Macro on: out_1 replaced in the same edge, out_valid[1] stays 1, occupancy unchanged.
- Different-slot concurrency:
  - Stimulus: write to slot 3 while acking slot 0, starting at occupancy=2.
  - Response: occupancy stays 2, out_valid[3]=1, out_valid[0]=0.
- Protocol violation: in_valid=1 to a full slot for one cycle, then in_valid=0 -> drop_err=1 and it remains set until rst.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg -- shared types and constants for demux_32_bit_4dest.
//   DEST_COUNT / DEST_W : number of destination slots and width of their index
//   dest_t              : destination slot index type
//   DEST_0..DEST_3      : named slot indices
//   popcount4()         : number of set bits in a 4-bit slot vector
`timescale 1ns/1ps
package demux_pkg;

  localparam int DEST_COUNT = 4;
  localparam int DEST_W     = 2;

  typedef logic [DEST_W-1:0] dest_t;

  localparam dest_t DEST_0 = 2'd0;
  localparam dest_t DEST_1 = 2'd1;
  localparam dest_t DEST_2 = 2'd2;
  localparam dest_t DEST_3 = 2'd3;

  function automatic logic [2:0] popcount4(input logic [DEST_COUNT-1:0] bits);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEST_COUNT; i++) begin
      cnt = cnt + {2'b00, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot -- one-entry holding buffer for a single destination.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   wr_en    : load wr_data this edge (top only asserts it when the slot may accept)
//   wr_data  : word to store
//   ack      : consumer takes the word this edge (already gated by valid)
//   data     : stored word; keeps its last value after being drained
//   valid    : slot holds an unconsumed word
// With DEMUX_ACK_BYPASS_EN the top may assert wr_en and ack together; the
// write winning over the ack is exactly the "replace" behaviour in that mode,
// and without the macro the two never coincide, so one rule serves both.
`timescale 1ns/1ps
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // NOTE: the data register is reset too, because a freshly reset slot must
  // read as zero; a pure datapath register would normally skip the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (wr_en) begin
        data <= wr_data;
      end
      valid <= wr_en | (valid & ~ack);
    end
  end

endmodule

// File: rtl/demux_32_bit_4dest.sv
// demux_32_bit_4dest -- steers one 32-bit producer stream into one of four
// one-entry slots, each drained independently through valid/ack.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_data/in_valid     : producer word and offer strobe
//   in_dest              : destination slot index
//   in_ready             : selected slot can accept this cycle (not a function of in_valid)
//   out_0..out_3         : registered slot contents
//   out_valid[i]         : slot i holds an unconsumed word
//   out_ack[i]           : consumer i takes out_i (ignored while slot i is empty)
//   occupancy            : registered popcount of out_valid
//   drop_err             : sticky; producer withdrew a stalled offer
// Build option: DEMUX_ACK_BYPASS_EN lets a same-cycle ack free the slot for
// the incoming word (in_ready then depends combinationally on out_ack).
`timescale 1ns/1ps
module demux_32_bit_4dest
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        in_dest,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ack,
  output logic [2:0]        occupancy,
  output logic              drop_err
);

  logic [DEST_COUNT-1:0] v;
  logic [DEST_COUNT-1:0] ack_eff;
  logic [DEST_COUNT-1:0] wr_en;
  logic [DEST_COUNT-1:0] next_v;
  logic [DATA_W-1:0]     slot_data [DEST_COUNT];
  logic                  accept;
  logic                  stall_q;

  assign ack_eff = out_ack & v;

`ifdef DEMUX_ACK_BYPASS_EN
  assign in_ready = !v[in_dest] || out_ack[in_dest];
`else
  assign in_ready = !v[in_dest];
`endif

  assign accept = in_valid && in_ready;

  // NOTE: every always_comb output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEST_COUNT; i++) begin
      wr_en[i] = accept && (in_dest == dest_t'(i));
    end
  end

  // Mirrors the slot update rule so occupancy lands on the same edge as v.
  assign next_v = wr_en | (v & ~ack_eff);

  for (genvar i = 0; i < DEST_COUNT; i++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data (in_data),
      .ack     (ack_eff[i]),
      .data    (slot_data[i]),
      .valid   (v[i])
    );
  end

  assign out_0     = slot_data[DEST_0];
  assign out_1     = slot_data[DEST_1];
  assign out_2     = slot_data[DEST_2];
  assign out_3     = slot_data[DEST_3];
  assign out_valid = v;

  // drop_err fires when an offer that stalled last cycle is withdrawn now.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      stall_q   <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      occupancy <= popcount4(next_v);
      stall_q   <= in_valid && !in_ready;
      drop_err  <= drop_err | (stall_q & ~in_valid);
    end
  end

endmodule

// File: tb/tb_demux_32_bit_4dest.sv
`timescale 1ns/1ps
module tb_demux_32_bit_4dest;

`ifdef DEMUX_ACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic [1:0]  in_dest;
  logic        in_ready;
  logic [31:0] out_0, out_1, out_2, out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic [2:0]  occupancy;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  demux_32_bit_4dest #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occupancy (occupancy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             vld;
    logic [1:0]       dest;
    logic [31:0]      data;
    logic [3:0]       ack;
    logic             exp_ready;
    logic [3:0]       exp_valid;
    logic [2:0]       exp_occ;
    logic             exp_drop;
    logic [3:0][31:0] exp_out;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [1:0] dest, input logic [31:0] data,
                              input logic [3:0] ack, input logic exp_ready,
                              input logic [3:0] exp_valid, input logic [2:0] exp_occ,
                              input logic exp_drop, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    vec_t r;
    r.vld = vld; r.dest = dest; r.data = data; r.ack = ack;
    r.exp_ready = exp_ready; r.exp_valid = exp_valid; r.exp_occ = exp_occ;
    r.exp_drop = exp_drop;
    r.exp_out = {d3, d2, d1, d0};
    return r;
  endfunction

  task automatic check_outs(input string tag, input logic [3:0][31:0] exp);
    check({tag, " out_0"}, out_0, exp[0]);
    check({tag, " out_1"}, out_1, exp[1]);
    check({tag, " out_2"}, out_2, exp[2]);
    check({tag, " out_3"}, out_3, exp[3]);
  endtask

  task automatic check_ready_all(input string tag);
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d);
      #0.1;
      check($sformatf("%s in_ready dest%0d", tag, d), {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] d1_at12;
    logic [31:0] d2_at6;

    d1_at12 = BYP ? 32'h12345678 : 32'hBBBB1111;
    d2_at6  = BYP ? 32'hDEADBEEF : 32'h33333333;

    // Four back-to-back writes, full-slot stall, drain, concurrency,
    // same-slot write+ack, unused ack, protocol violation, refill.
    vecs[0]  = mk(1, 0, 32'h11111111, 4'b0000, 1, 4'b0001, 1, 0, 32'h11111111, 0, 0, 0);
    vecs[1]  = mk(1, 1, 32'h22222222, 4'b0000, 1, 4'b0011, 2, 0, 32'h11111111, 32'h22222222, 0, 0);
    vecs[2]  = mk(1, 2, 32'h33333333, 4'b0000, 1, 4'b0111, 3, 0, 32'h11111111, 32'h22222222, 32'h33333333, 0);
    vecs[3]  = mk(1, 3, 32'h44444444, 4'b0000, 1, 4'b1111, 4, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    vecs[4]  = mk(1, 2, 32'hDEADBEEF, 4'b0000, 0, 4'b1111, 4, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    vecs[5]  = mk(1, 2, 32'hDEADBEEF, 4'b0100, BYP, BYP ? 4'b1111 : 4'b1011, BYP ? 3'd4 : 3'd3, 0,
                  32'h11111111, 32'h22222222, d2_at6, 32'h44444444);
    vecs[6]  = mk(!BYP, 2, 32'hDEADBEEF, 4'b0000, !BYP, 4'b1111, 4, 0,
                  32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444);
    vecs[7]  = mk(0, 0, 32'h0, 4'b1111, BYP, 4'b0000, 0, 0,
                  32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444);
    vecs[8]  = mk(1, 0, 32'hAAAA0000, 4'b0000, 1, 4'b0001, 1, 0,
                  32'hAAAA0000, 32'h22222222, 32'hDEADBEEF, 32'h44444444);
    vecs[9]  = mk(1, 1, 32'hBBBB1111, 4'b0000, 1, 4'b0011, 2, 0,
                  32'hAAAA0000, 32'hBBBB1111, 32'hDEADBEEF, 32'h44444444);
    vecs[10] = mk(1, 3, 32'hCCCC3333, 4'b0001, 1, 4'b1010, 2, 0,
                  32'hAAAA0000, 32'hBBBB1111, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[11] = mk(1, 1, 32'h12345678, 4'b0010, BYP, BYP ? 4'b1010 : 4'b1000, BYP ? 3'd2 : 3'd1, 0,
                  32'hAAAA0000, d1_at12, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[12] = mk(!BYP, 1, 32'h12345678, 4'b0000, !BYP, 4'b1010, 2, 0,
                  32'hAAAA0000, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[13] = mk(0, 0, 32'h0, 4'b0101, 1, 4'b1010, 2, 0,
                  32'hAAAA0000, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[14] = mk(1, 3, 32'h55555555, 4'b0000, 0, 4'b1010, 2, 0,
                  32'hAAAA0000, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[15] = mk(0, 3, 32'h55555555, 4'b0000, 0, 4'b1010, 2, 1,
                  32'hAAAA0000, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[16] = mk(0, 0, 32'h0, 4'b0000, 1, 4'b1010, 2, 1,
                  32'hAAAA0000, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);
    vecs[17] = mk(1, 0, 32'h66666666, 4'b0000, 1, 4'b1011, 3, 1,
                  32'h66666666, 32'h12345678, 32'hDEADBEEF, 32'hCCCC3333);

    // Power-on reset.
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_dest = '0; out_ack = '0;
    #3;
    check("por out_valid", {28'b0, out_valid}, 32'h0);
    check("por occupancy", {29'b0, occupancy}, 32'h0);
    check("por drop_err", {31'b0, drop_err}, 32'h0);
    check_outs("por", '0);
    check_ready_all("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      in_valid = vecs[i].vld;
      in_dest  = vecs[i].dest;
      in_data  = vecs[i].data;
      out_ack  = vecs[i].ack;
      @(negedge clk);
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), {28'b0, out_valid}, {28'b0, vecs[i].exp_valid});
      check($sformatf("v%0d occupancy", i), {29'b0, occupancy}, {29'b0, vecs[i].exp_occ});
      check($sformatf("v%0d drop_err", i), {31'b0, drop_err}, {31'b0, vecs[i].exp_drop});
      check_outs($sformatf("v%0d", i), vecs[i].exp_out);
    end

    // Mid-run asynchronous reset with v=4'b1011 and a write pending to slot 1.
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h77777777; out_ack = '0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst out_valid", {28'b0, out_valid}, 32'h0);
    check("mrst occupancy", {29'b0, occupancy}, 32'h0);
    check("mrst drop_err", {31'b0, drop_err}, 32'h0);
    check_outs("mrst", '0);
    check_ready_all("mrst");
    in_dest = 2'd1;
    @(posedge clk); #1;
    check("mrst held out_1", out_1, 32'h0);
    check("mrst held out_valid", {28'b0, out_valid}, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post rst out_valid", {28'b0, out_valid}, 32'h0);
    check("post rst drop_err", {31'b0, drop_err}, 32'h0);

    // One-cycle latency after reset release: accepted word visible next edge.
    in_valid = 1'b1; in_dest = 2'd2; in_data = 32'h0BADF00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post rst out_2", out_2, 32'h0BADF00D);
    check("post rst occupancy", {29'b0, occupancy}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
